// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RISC-V core.
// Captures decode fields every cycle, detects load-use hazards against the
// instruction currently held in ID/EX, inserts a single bubble for such a
// hazard while holding PC and IF/ID, and bubbles on a taken-branch flush or
// an empty IF/ID slot. A saturating counter tracks hazard bubbles only.
module id_ex_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_id_valid,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic [4:0]       if_id_rd,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [XLEN-1:0]  id_rdata1,
    input  logic [XLEN-1:0]  id_rdata2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [8:0]       id_ctrl,
    input  logic             flush,
    output logic             id_ex_valid,
    output logic [4:0]       id_ex_rs1,
    output logic [4:0]       id_ex_rs2,
    output logic [4:0]       id_ex_rd,
    output logic [XLEN-1:0]  id_ex_rdata1,
    output logic [XLEN-1:0]  id_ex_rdata2,
    output logic [XLEN-1:0]  id_ex_imm,
    output logic [XLEN-1:0]  id_ex_pc,
    output logic [8:0]       id_ex_ctrl,
    output logic             pc_write,
    output logic             if_id_write,
    output logic [CNT_W-1:0] stall_count
);

    // Bit position of MemRead inside the packed control word
    // {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,Branch,ALUOp[1:0],Jump}.
    localparam int CTRL_MEMREAD = 7;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Pipeline state registers and their next-state values.
    logic             valid_q,  valid_d;
    logic [4:0]       rs1_q,    rs1_d;
    logic [4:0]       rs2_q,    rs2_d;
    logic [4:0]       rd_q,     rd_d;
    logic [XLEN-1:0]  rdata1_q, rdata1_d;
    logic [XLEN-1:0]  rdata2_q, rdata2_d;
    logic [XLEN-1:0]  imm_q,    imm_d;
    logic [XLEN-1:0]  pc_q,     pc_d;
    logic [8:0]       ctrl_q,   ctrl_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    logic             load_in_ex_s;
    logic             rs1_match_s;
    logic             rs2_match_s;
    logic             hazard_s;
    logic             stall_s;

    // Load-use detection: ID/EX holds a real load writing a non-zero register
    // that the instruction in IF/ID actually reads.
    always_comb begin
        load_in_ex_s = 1'b0;
        rs1_match_s  = 1'b0;
        rs2_match_s  = 1'b0;
        hazard_s     = 1'b0;
        if (valid_q && ctrl_q[CTRL_MEMREAD] && (rd_q != 5'd0)) begin
            load_in_ex_s = 1'b1;
        end else begin
            load_in_ex_s = 1'b0;
        end
        if (id_rs1_used && (if_id_rs1 == rd_q)) begin
            rs1_match_s = 1'b1;
        end else begin
            rs1_match_s = 1'b0;
        end
        if (id_rs2_used && (if_id_rs2 == rd_q)) begin
            rs2_match_s = 1'b1;
        end else begin
            rs2_match_s = 1'b0;
        end
        if (load_in_ex_s && if_id_valid && (rs1_match_s || rs2_match_s)) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end

    // A flush redirects the front end, so it always wins over a stall.
    always_comb begin
        stall_s = 1'b0;
        if (hazard_s && !flush) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Front-end hold controls; forced to write-enable while in reset so the
    // PC and IF/ID are never frozen by stale pipeline state.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if (!rst_n) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
        end else if (stall_s) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
        end
    end

    // Next-state selection: flush > hazard > empty slot > normal capture.
    always_comb begin
        valid_d  = 1'b0;
        rs1_d    = 5'd0;
        rs2_d    = 5'd0;
        rd_d     = 5'd0;
        rdata1_d = {XLEN{1'b0}};
        rdata2_d = {XLEN{1'b0}};
        imm_d    = {XLEN{1'b0}};
        pc_d     = {XLEN{1'b0}};
        ctrl_d   = 9'd0;
        cnt_d    = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (hazard_s) begin
            valid_d = 1'b0;
            if (cnt_q == CNT_MAX) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (!if_id_valid) begin
            valid_d = 1'b0;
        end else begin
            valid_d  = 1'b1;
            rs1_d    = if_id_rs1;
            rs2_d    = if_id_rs2;
            rd_d     = if_id_rd;
            rdata1_d = id_rdata1;
            rdata2_d = id_rdata2;
            imm_d    = id_imm;
            pc_d     = id_pc;
            ctrl_d   = id_ctrl;
        end
    end

    // Pipeline register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            rs1_q    <= 5'd0;
            rs2_q    <= 5'd0;
            rd_q     <= 5'd0;
            rdata1_q <= {XLEN{1'b0}};
            rdata2_q <= {XLEN{1'b0}};
            imm_q    <= {XLEN{1'b0}};
            pc_q     <= {XLEN{1'b0}};
            ctrl_q   <= 9'd0;
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            valid_q  <= valid_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
        end
    end

    assign id_ex_valid  = valid_q;
    assign id_ex_rs1    = rs1_q;
    assign id_ex_rs2    = rs2_q;
    assign id_ex_rd     = rd_q;
    assign id_ex_rdata1 = rdata1_q;
    assign id_ex_rdata2 = rdata2_q;
    assign id_ex_imm    = imm_q;
    assign id_ex_pc     = pc_q;
    assign id_ex_ctrl   = ctrl_q;
    assign stall_count  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed load-use scenarios followed by
// biased random traffic, checked against a transaction-level reference model.
module tb_id_ex_stage;

    localparam int XLEN = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             if_id_valid;
    logic [4:0]       if_id_rs1, if_id_rs2, if_id_rd;
    logic             id_rs1_used, id_rs2_used;
    logic [XLEN-1:0]  id_rdata1, id_rdata2, id_imm, id_pc;
    logic [8:0]       id_ctrl;
    logic             flush;

    logic             id_ex_valid, s_valid;
    logic [4:0]       id_ex_rs1, id_ex_rs2, id_ex_rd, s_rs1, s_rs2, s_rd;
    logic [XLEN-1:0]  id_ex_rdata1, id_ex_rdata2, id_ex_imm, id_ex_pc;
    logic [XLEN-1:0]  s_rdata1, s_rdata2, s_imm, s_pc;
    logic [8:0]       id_ex_ctrl, s_ctrl;
    logic             pc_write, if_id_write, s_pc_write, s_if_id_write;
    logic [15:0]      stall_count;
    logic [3:0]       s_stall_count;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .if_id_valid(if_id_valid),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_rd(if_id_rd),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc(id_pc),
        .id_ctrl(id_ctrl), .flush(flush),
        .id_ex_valid(id_ex_valid), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_rdata1(id_ex_rdata1), .id_ex_rdata2(id_ex_rdata2),
        .id_ex_imm(id_ex_imm), .id_ex_pc(id_ex_pc), .id_ex_ctrl(id_ex_ctrl),
        .pc_write(pc_write), .if_id_write(if_id_write), .stall_count(stall_count)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation.
    id_ex_stage #(.XLEN(XLEN), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .if_id_valid(if_id_valid),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_rd(if_id_rd),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc(id_pc),
        .id_ctrl(id_ctrl), .flush(flush),
        .id_ex_valid(s_valid), .id_ex_rs1(s_rs1), .id_ex_rs2(s_rs2),
        .id_ex_rd(s_rd), .id_ex_rdata1(s_rdata1), .id_ex_rdata2(s_rdata2),
        .id_ex_imm(s_imm), .id_ex_pc(s_pc), .id_ex_ctrl(s_ctrl),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write), .stall_count(s_stall_count)
    );

    // Control encodings {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,Branch,ALUOp,Jump}
    localparam logic [8:0] C_ADD  = 9'b1_0_0_0_0_0_10_0;
    localparam logic [8:0] C_LD   = 9'b1_1_0_1_1_0_00_0;
    localparam logic [8:0] C_ADDI = 9'b1_0_0_0_1_0_10_0;

    typedef struct {
        logic            rst_n;
        logic            valid;
        logic [4:0]      rs1, rs2, rd;
        logic            u1, u2;
        logic [XLEN-1:0] d1, d2, imm, pc;
        logic [8:0]      ctrl;
        logic            flush;
    } in_t;

    // Reference model of what the ID/EX register holds.
    typedef struct {
        logic            valid;
        logic [4:0]      rs1, rs2, rd;
        logic [XLEN-1:0] d1, d2, imm, pc;
        logic [8:0]      ctrl;
    } stage_t;

    typedef struct { int cyc; logic pcw; } comb_exp_t;
    typedef struct { int cyc; stage_t st; int cnt16; int cnt4; } reg_exp_t;

    comb_exp_t comb_q[$];
    reg_exp_t  reg_q[$];

    int     cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    stage_t m;
    int     m_cnt = 0;
    in_t    last_in;
    logic   last_stall = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic model_hazard(input stage_t s, input in_t x);
        logic is_load;
        is_load = s.valid && (s.ctrl == C_LD || s.ctrl[7]) && s.rd != 5'd0;
        return is_load && x.valid && ((x.u1 && x.rs1 == s.rd) || (x.u2 && x.rs2 == s.rd));
    endfunction

    function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic u1, input logic u2, input logic [8:0] ctrl,
                               input logic fl, input logic rst);
        in_t x;
        x.rst_n = rst; x.valid = 1'b1; x.rs1 = rs1; x.rs2 = rs2; x.rd = rd;
        x.u1 = u1; x.u2 = u2; x.ctrl = ctrl; x.flush = fl;
        x.d1 = {$urandom(), $urandom()}; x.d2 = {$urandom(), $urandom()};
        x.imm = {$urandom(), $urandom()}; x.pc = {$urandom(), $urandom()};
        return x;
    endfunction

    function automatic in_t rand_in();
        in_t x;
        logic [8:0] c;
        c = 9'($urandom());
        c[7] = ($urandom_range(0, 1) == 0);
        x = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               1'($urandom()), 1'($urandom()), c, ($urandom_range(0, 11) == 0),
               ($urandom_range(0, 49) != 0));
        x.valid = ($urandom_range(0, 6) != 0);
        return x;
    endfunction

    // Apply one cycle of inputs after the edge, predict, and queue expectations.
    task automatic drive(input in_t x);
        logic   haz;
        stage_t nx;
        reg_exp_t re;
        comb_exp_t ce;
        @(posedge clk);
        #1;
        rst_n = x.rst_n; if_id_valid = x.valid; if_id_rs1 = x.rs1; if_id_rs2 = x.rs2;
        if_id_rd = x.rd; id_rs1_used = x.u1; id_rs2_used = x.u2; id_rdata1 = x.d1;
        id_rdata2 = x.d2; id_imm = x.imm; id_pc = x.pc; id_ctrl = x.ctrl; flush = x.flush;
        haz = model_hazard(m, x);
        ce.cyc = cyc;
        ce.pcw = !x.rst_n ? 1'b1 : !(haz && !x.flush);
        comb_q.push_back(ce);
        nx = '{valid: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, d1: '0, d2: '0, imm: '0, pc: '0, ctrl: 9'd0};
        if (!x.rst_n) begin
            m_cnt = 0;
        end else if (x.flush) begin
        end else if (haz) begin
            m_cnt = m_cnt + 1;
        end else if (x.valid) begin
            nx = '{valid: 1'b1, rs1: x.rs1, rs2: x.rs2, rd: x.rd, d1: x.d1, d2: x.d2,
                   imm: x.imm, pc: x.pc, ctrl: x.ctrl};
        end
        re.cyc = cyc + 1;
        re.st = nx;
        re.cnt16 = (m_cnt > 65535) ? 65535 : m_cnt;
        re.cnt4 = (m_cnt > 15) ? 15 : m_cnt;
        reg_q.push_back(re);
        m = nx;
        last_in = x;
        last_stall = x.rst_n && haz && !x.flush;
    endtask

    // Monitor: compare DUT outputs against queued predictions for this cycle.
    always @(negedge clk) begin
        while (comb_q.size() > 0 && comb_q[0].cyc == cyc) begin
            comb_exp_t ce;
            ce = comb_q.pop_front();
            n_checks++;
            if (pc_write !== ce.pcw || if_id_write !== ce.pcw) begin
                n_fail++;
                $display("FAIL hold_ctrl cyc=%0d pc_write=%b if_id_write=%b expected %b",
                         cyc, pc_write, if_id_write, ce.pcw);
            end
        end
        while (reg_q.size() > 0 && reg_q[0].cyc == cyc) begin
            reg_exp_t re;
            logic [4+15+64*4+9+16-1:0] act, exp;
            re = reg_q.pop_front();
            act = {id_ex_valid, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_rdata1, id_ex_rdata2,
                   id_ex_imm, id_ex_pc, id_ex_ctrl, stall_count};
            exp = {re.st.valid, re.st.rs1, re.st.rs2, re.st.rd, re.st.d1, re.st.d2,
                   re.st.imm, re.st.pc, re.st.ctrl, 16'(re.cnt16)};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL id_ex_regs cyc=%0d got v=%b rs1=%0d rs2=%0d rd=%0d ctrl=%h cnt=%0d pc=%h want v=%b rs1=%0d rs2=%0d rd=%0d ctrl=%h cnt=%0d pc=%h",
                         cyc, id_ex_valid, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_ctrl, stall_count, id_ex_pc,
                         re.st.valid, re.st.rs1, re.st.rs2, re.st.rd, re.st.ctrl, re.cnt16, re.st.pc);
            end
            n_checks++;
            if (s_stall_count !== 4'(re.cnt4)) begin
                n_fail++;
                $display("FAIL sat_count cyc=%0d got %0d expected %0d", cyc, s_stall_count, re.cnt4);
            end
        end
    end

    initial begin
        in_t x;
        m = '{valid: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, d1: '0, d2: '0, imm: '0, pc: '0, ctrl: 9'd0};
        x = rand_in();
        rst_n = 1'b0; if_id_valid = x.valid; if_id_rs1 = x.rs1; if_id_rs2 = x.rs2;
        if_id_rd = x.rd; id_rs1_used = x.u1; id_rs2_used = x.u2; id_rdata1 = x.d1;
        id_rdata2 = x.d2; id_imm = x.imm; id_pc = x.pc; id_ctrl = x.ctrl; flush = x.flush;

        // Reset with random inputs.
        repeat (2) begin x = rand_in(); x.rst_n = 1'b0; drive(x); end
        // add x3,x1,x2
        drive(mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, C_ADD, 1'b0, 1'b1));
        // ld x5 then add x6,x5,x7: stall one cycle, then capture held add.
        drive(mk(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LD, 1'b0, 1'b1));
        x = mk(5'd5, 5'd7, 5'd6, 1'b1, 1'b1, C_ADD, 1'b0, 1'b1);
        drive(x); drive(x);
        // ld x5 then addi with rs2 field 5 but unused: no stall.
        drive(mk(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LD, 1'b0, 1'b1));
        drive(mk(5'd1, 5'd5, 5'd8, 1'b1, 1'b0, C_ADDI, 1'b0, 1'b1));
        // ld x0 then use x0: no stall.
        drive(mk(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, C_LD, 1'b0, 1'b1));
        drive(mk(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, C_ADD, 1'b0, 1'b1));
        // Hazard coinciding with flush.
        drive(mk(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LD, 1'b0, 1'b1));
        drive(mk(5'd2, 5'd5, 5'd6, 1'b1, 1'b1, C_ADD, 1'b1, 1'b1));
        // Reset asserted mid-stall.
        drive(mk(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LD, 1'b0, 1'b1));
        drive(mk(5'd5, 5'd2, 5'd6, 1'b1, 1'b1, C_ADD, 1'b0, 1'b0));
        // 17 back-to-back load-use pairs from a zero count.
        for (int i = 0; i < 17; i++) begin
            drive(mk(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LD, 1'b0, 1'b1));
            x = mk(5'd5, 5'd7, 5'd6, 1'b1, 1'b1, C_ADD, 1'b0, 1'b1);
            drive(x); drive(x);
        end
        // Random traffic; stalled instructions are held like a real IF/ID.
        for (int i = 0; i < 3000; i++) begin
            if (last_stall) begin
                x = last_in;
                x.flush = ($urandom_range(0, 11) == 0);
                x.rst_n = ($urandom_range(0, 49) != 0);
            end else begin
                x = rand_in();
            end
            drive(x);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (comb_q.size() != 0 || reg_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain comb_left=%0d reg_left=%0d expected 0", comb_q.size(), reg_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
